shared_mem_responder: RTL
=========================

Name: shared_mem_responder

Overview:
- Memory-side responder for the four-CPU parallel processor.
- Accepts REQ/RW/ADDRESS/write-data requests from each CPU and arbitrates them round-robin onto one shared 8-bit memory.
- Completes each access with a one-cycle ACK plus read data, and drives per-CPU BUSY while another CPU owns the memory.
- Includes a preload port that the memory-driver path uses to initialise contents.

Parameters:
NUM_CPU, 4, number of requesting CPUs (grant index width is clog2(NUM_CPU))
ADDR_W, 8, address width
DATA_W, 8, data width
DEPTH, 256, memory words (2**ADDR_W)
ACCESS_LAT, 2, cycles from grant to ACK; legal range is 1 or more

Ports:
clock  input  1  system clock, all logic on posedge
RESET  input  1  synchronous, active-high reset
REQ  input  NUM_CPU  per-CPU request
RW  input  NUM_CPU  per-CPU direction: 1 = write, 0 = read
ADDRESS  input  NUM_CPU*ADDR_W  per-CPU address; CPU i occupies bits [i*ADDR_W +: ADDR_W]
WDATA  input  NUM_CPU*DATA_W  per-CPU write data, same packing as ADDRESS
LOAD_EN  input  1  preload write strobe
LOAD_ADDR  input  ADDR_W  preload address
LOAD_DATA  input  DATA_W  preload data
ACK  output  NUM_CPU  one-cycle completion pulse, one bit per CPU
RDATA  output  DATA_W  read data; valid in the cycle ACK is high for a read
BUSY  output  NUM_CPU  BUSY[i] = 1 while memory is owned by a CPU other than i
GRANT_VALID  output  1  1 while a transaction is in progress
GRANT_ID  output  clog2(NUM_CPU)  index of the current or last granted CPU

Behaviour:
- Reset values: ACK=0, RDATA=0, BUSY=0, GRANT_VALID=0, GRANT_ID=0, round-robin pointer=0, state=IDLE. Memory contents are not reset.
- Requester rule: a CPU holds REQ, RW, ADDRESS and WDATA stable until its ACK, then drops REQ.
- Request fields are latched at the grant edge. Later changes to them, including REQ dropping early, are ignored and the transaction still completes.
- IDLE:
  - If LOAD_EN=1: mem[LOAD_ADDR] <= LOAD_DATA and no grant is made that cycle (load has priority).
  - Otherwise, if any REQ=1: grant the first requester found scanning from the pointer upward, modulo NUM_CPU.
  - On grant: latch the request, set GRANT_ID, GRANT_VALID=1, clear the latency counter, go to ACCESS.
  - LOAD_EN is ignored in every state other than IDLE.
- ACCESS:
  - The counter increments each cycle.
  - At the edge where the counter reaches ACCESS_LAT-1:
    - write: mem[addr] <= wdata, RDATA unchanged.
    - read: RDATA <= mem[addr].
    - ACK[GRANT_ID] <= 1, go to RESP.
  - Result: ACK is high exactly ACCESS_LAT cycles after the grant edge.
- RESP:
  - ACK returns to 0 after one cycle.
  - Pointer <= GRANT_ID+1 (wraps from NUM_CPU-1 to 0).
  - Go to RELEASE.
- RELEASE:
  - Stay here while REQ[GRANT_ID]=1. No second ACK is ever issued.
  - When REQ[GRANT_ID]=0, set GRANT_VALID <= 0 and go to IDLE.
  - Arbitration resumes in the following cycle.
- BUSY[i] = GRANT_VALID and (i != GRANT_ID), registered with the state. BUSY[GRANT_ID] stays 0.
- Back-to-back: minimum spacing between two ACKs is ACCESS_LAT+3 cycles.
- No starvation: each requester holding REQ is granted within NUM_CPU transactions.
- RDATA holds its value until the next read ACK.
- RESET while in ACCESS before the commit edge: the write is not performed, no ACK is issued, all state returns to reset values.
- A read of an address never written or preloaded returns the array value; the bench must preload every address it reads.

Test Plan:
1. Preload LOAD_ADDR=0x10, LOAD_DATA=0xA5; CPU0 reads 0x10 with ACCESS_LAT=2 -> ACK[0] high 2 cycles after grant for exactly 1 cycle, RDATA=0xA5, BUSY=4'b1110 during the transaction and 0 otherwise.
2. CPU1 writes 0x3C to 0x20, then CPU2 reads 0x20 -> RDATA=0x3C at ACK[2]; RDATA is unchanged at ACK[1] for the write.
3. All four REQ rise on the same cycle after reset -> grants in order 0,1,2,3, each with exactly one ACK; GRANT_ID sequence is 0,1,2,3.
4. After CPU1 is served, CPU0 and CPU2 request simultaneously -> CPU2 is granted first, then CPU0.
5. CPU3 holds REQ for 4 cycles after its ACK -> no second ACK, GRANT_VALID stays 1 and BUSY stays 4'b0111 until REQ[3] drops, then both clear the next cycle.
6. Preload 0x40=0x00; CPU0 writes 0x55 to 0x40; RESET pulses in the first ACCESS cycle -> no ACK and outputs at reset values; a subsequent read of 0x40 returns 0x00.

Source files
------------

// File: rtl/shared_mem_responder_if.sv
`default_nettype none
// ============================================================================
// shared_mem_responder_if : CPU request / memory response bundle
// Rev 1.0
// ============================================================================
interface shared_mem_responder_if #(
  parameter int NUM_CPU = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

  logic [NUM_CPU-1:0]        REQ;
  logic [NUM_CPU-1:0]        RW;
  logic [NUM_CPU*ADDR_W-1:0] ADDRESS;
  logic [NUM_CPU*DATA_W-1:0] WDATA;
  logic                      LOAD_EN;
  logic [ADDR_W-1:0]         LOAD_ADDR;
  logic [DATA_W-1:0]         LOAD_DATA;
  logic [NUM_CPU-1:0]        ACK;
  logic [DATA_W-1:0]         RDATA;
  logic [NUM_CPU-1:0]        BUSY;
  logic                      GRANT_VALID;
  logic [ID_W-1:0]           GRANT_ID;

  modport slave (
    input  REQ, RW, ADDRESS, WDATA, LOAD_EN, LOAD_ADDR, LOAD_DATA,
    output ACK, RDATA, BUSY, GRANT_VALID, GRANT_ID
  );

  modport master (
    output REQ, RW, ADDRESS, WDATA, LOAD_EN, LOAD_ADDR, LOAD_DATA,
    input  ACK, RDATA, BUSY, GRANT_VALID, GRANT_ID
  );
endinterface
`default_nettype wire

// File: rtl/shared_mem_responder.sv
`default_nettype none
// ============================================================================
// shared_mem_responder : round-robin arbiter in front of one shared memory
// Rev 1.0
// ============================================================================
module shared_mem_responder #(
  parameter int NUM_CPU    = 4,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 2**ADDR_W,
  parameter int ACCESS_LAT = 2
) (
  input  logic                 clock,
  input  logic                 RESET,
  shared_mem_responder_if.slave bus
);
  localparam int ID_W  = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
  localparam int CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic                gv_q, gv_d;
  logic [NUM_CPU-1:0]  busy_q, busy_d;
  logic [NUM_CPU-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic                w_found;
  logic [ID_W-1:0]     w_pick;
  int                  w_idx;

  logic [DATA_W-1:0]   mem [DEPTH];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    gv_d        = gv_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    w_mem_we    = 1'b0;
    w_mem_addr  = addr_q;
    w_mem_wdata = wdata_q;
    w_found     = 1'b0;
    w_pick      = '0;
    w_idx       = 0;

    // Round-robin scan: first requester at or above the pointer, wrapping.
    for (int k = 0; k < NUM_CPU; k++) begin
      w_idx = (int'(ptr_q) + k) % NUM_CPU;
      if (!w_found && bus.REQ[w_idx]) begin
        w_found = 1'b1;
        w_pick  = ID_W'(w_idx);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.LOAD_EN) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = bus.LOAD_ADDR;
          w_mem_wdata = bus.LOAD_DATA;
        end else if (w_found) begin
          gid_d   = w_pick;
          gv_d    = 1'b1;
          cnt_d   = '0;
          rw_d    = bus.RW[w_pick];
          addr_d  = bus.ADDRESS[int'(w_pick)*ADDR_W +: ADDR_W];
          wdata_d = bus.WDATA[int'(w_pick)*DATA_W +: DATA_W];
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == CNT_W'(ACCESS_LAT-1)) begin
          if (rw_q) begin
            w_mem_we = 1'b1;
          end else begin
            rdata_d = mem[addr_q];
          end
          ack_d[gid_q] = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        ptr_d   = (gid_q == ID_W'(NUM_CPU-1)) ? '0 : gid_q + 1'b1;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus.REQ[gid_q]) begin
          gv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = '0;
    if (gv_d) begin
      busy_d        = '1;
      busy_d[gid_d] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      gv_q    <= 1'b0;
      busy_q  <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      gv_q    <= gv_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Contents survive reset, but a reset aborts any write on that same edge.
  always_ff @(posedge clock) begin
    if (w_mem_we && !RESET) begin
      mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign bus.ACK         = ack_q;
  assign bus.RDATA       = rdata_q;
  assign bus.BUSY        = busy_q;
  assign bus.GRANT_VALID = gv_q;
  assign bus.GRANT_ID    = gid_q;
endmodule
`default_nettype wire
